muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Iterative controller for the RV32M extension, i.e. R-type ops with opcode 0110011 and funct7 0000001. The single-cycle EX ALU returns zero for these ops.
- Accepts one M-op from EX and holds the pipeline via stall while a shift-add multiplier or restoring divider iterates.
- Returns the result for one cycle so EX can forward it to MEM/WB.
- Sits beside the EX stage, under hazard/flush control.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  EX holds an M-op (decoded opcode/funct7 match)
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  in  XLEN  operand A
rs2_val  in  XLEN  operand B
flush  in  1  kill current op (branch mispredict/trap)
req_ready  out  1  controller idle, can accept
busy  out  1  state != IDLE
stall  out  1  freeze IF/ID/EX
resp_valid  out  1  one-cycle result strobe
resp_result  out  XLEN  result, held until next resp_valid

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst_n is asynchronous, active-low.
- States are IDLE, MUL, DIV, DONE.
- Reset (async, any time including mid-operation):
  - state IDLE, counter 0, resp_valid 0, resp_result 0.
  - req_ready 1, busy 0, stall 0.
- Accept: req_valid && state==IDLE && !flush.
  - Latches funct3 and operands; later changes on the inputs are ignored until IDLE.
  - req_valid while busy is ignored.
- MUL path (funct3[2]=0):
  - Operands become 2*XLEN-bit per signedness: MULH s×s, MULHSU s×u, MULHU u×u, MUL low half.
  - XLEN shift-add iterations, one per cycle, counter XLEN-1 down to 0, then DONE.
  - MUL returns product[XLEN-1:0]; the high variants return product[2XLEN-1:XLEN].
- DIV path (funct3[2]=1):
  - Signed ops divide |rs1| by |rs2| unsigned, using XLEN restoring iterations.
  - Quotient sign is rs1^rs2; remainder takes the sign of rs1.
- Fast paths: accept -> DONE directly, no iteration.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- Latency: let T be the accept cycle.
  - Normal ops: DONE and resp_valid fall in cycle T+XLEN+1.
  - Fast paths: cycle T+1.
- DONE:
  - resp_valid=1 and resp_result updated in that cycle.
  - Next state is IDLE unconditionally; the same instruction is never re-accepted.
- stall = req_valid && !flush && state!=DONE (combinational).
  - High in the accept cycle and every iteration cycle.
  - Low in the DONE cycle, so the pipeline advances with the result.
- flush:
  - Next edge forces IDLE from any state; no resp_valid is issued.
  - resp_result keeps its old value; stall drops in the flush cycle itself.
  - flush in the DONE cycle still suppresses resp_valid.
- req_ready = (state==IDLE).
- resp_valid is never high for two consecutive cycles.
- All arithmetic is modulo 2^XLEN unless stated above.

Test Plan:
- MUL 7 × 0xFFFFFFFD, accept at cycle T -> stall high cycles T..T+32, resp_valid only at T+33, resp_result 0xFFFFFFEB, busy low at T+34.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- Divides:
  - DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU -> 2.
- Fast paths, resp_valid at T+1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIVU flushed at iteration 10 -> no resp_valid, IDLE next cycle, resp_result unchanged. A following MUL 3×4 is accepted immediately and returns 12.
- rst_n pulsed low mid-DIV -> same cycle (async): busy 0, stall 0, resp_valid 0, resp_result 0. After release, a MULHU 2×3 request completes normally and returns 0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide controller beside the EX stage.
// It takes one M-op from EX and holds IF/ID/EX frozen (stall) while a
// shift-add multiplier or restoring divider runs for XLEN cycles. The result
// is then strobed out for exactly one cycle.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   req_valid     - EX holds a decoded M-op
//   funct3        - MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU selector
//   rs1_val/rs2_val - operands A and B
//   flush         - kill the current op (mispredict/trap)
//   req_ready     - idle, can accept a new op
//   busy          - an op is in flight
//   stall         - freeze IF/ID/EX
//   resp_valid    - one-cycle result strobe
//   resp_result   - result, held until the next resp_valid
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            req_ready,
    output logic            busy,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Two's-complement negate when en is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + ONE) : v;
    endfunction

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                fast_q, fast_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    // MUL: shifted multiplicand / multiplier; DIV: divisor (low half) / dividend.
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    // MUL: product accumulator; DIV: {remainder, quotient}; fast: result in low half.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                div_signed_s;
    logic                a_signed_s;
    logic [2*XLEN-1:0]   addend_s;
    logic [XLEN:0]       rem_shift_s;
    logic [XLEN:0]       diff_s;
    logic [XLEN-1:0]     final_res_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 3'b000;
            fast_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            fast_q    <= fast_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    // Final result selection from the latched op and accumulator.
    always_comb begin
        final_res_s = acc_q[XLEN-1:0];
        if (fast_q) begin
            final_res_s = acc_q[XLEN-1:0];
        end else if (!op_q[2]) begin
            final_res_s = (op_q[1:0] == 2'b00) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            final_res_s = neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q);
        end else begin
            final_res_s = neg_if(acc_q[XLEN-1:0], neg_quo_q);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        fast_d    = fast_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;

        div_signed_s = ~funct3[0];
        a_signed_s   = (funct3[1:0] != 2'b11);
        addend_s     = mplier_q[0] ? mcand_q : '0;
        rem_shift_s  = {acc_q[2*XLEN-1:XLEN], mplier_q[XLEN-1]};
        diff_s       = rem_shift_s - {1'b0, mcand_q[XLEN-1:0]};

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d      = funct3;
                    cnt_d     = CW'(XLEN-1);
                    fast_d    = 1'b0;
                    neg_quo_d = div_signed_s & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                    neg_rem_d = div_signed_s & rs1_val[XLEN-1];
                    acc_d     = '0;
                    if (!funct3[2]) begin
                        mcand_d  = {{XLEN{a_signed_s & rs1_val[XLEN-1]}}, rs1_val};
                        mplier_d = rs2_val;
                        state_d  = S_MUL;
                    end else if (rs2_val == '0) begin
                        fast_d  = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, (funct3[1] ? rs1_val : {XLEN{1'b1}})};
                        state_d = S_DONE;
                    end else if (div_signed_s && rs1_val == MIN_INT && rs2_val == {XLEN{1'b1}}) begin
                        fast_d  = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, (funct3[1] ? {XLEN{1'b0}} : MIN_INT)};
                        state_d = S_DONE;
                    end else begin
                        mplier_d = neg_if(rs1_val, neg_rem_d);
                        mcand_d  = {{XLEN{1'b0}}, neg_if(rs2_val, div_signed_s & rs2_val[XLEN-1])};
                        state_d  = S_DIV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // A signed multiplier's MSB carries weight -2^(XLEN-1), so the
                // last partial product is subtracted rather than added.
                if (cnt_q == '0 && op_q[1:0] == 2'b01) begin
                    acc_d = acc_q - addend_s;
                end else begin
                    acc_d = acc_q + addend_s;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                // Restoring step: no borrow out of the trial subtract sets the quotient bit.
                if (!diff_s[XLEN]) begin
                    acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
                mplier_d = mplier_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush) begin
                    result_d = final_res_s;
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Handshake outputs; the DONE-cycle result bypasses the holding register.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        stall       = rst_n & req_valid & ~flush & (state_q != S_DONE);
        resp_valid  = (state_q == S_DONE) & ~flush;
        if (resp_valid) begin
            resp_result = final_res_s;
        end else begin
            resp_result = result_q;
        end
    end
endmodule
